// File: rtl/posit_add_issue.sv
// Operand issue and result collection stage in front of posit_add (N=32, es=2).
// Buffers operand pairs, launches one add at a time, returns sums with a done-watchdog.
module posit_add_issue #(
    parameter int N       = 32,
    parameter int es      = 2,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_a,
    input  logic [N-1:0]           in_b,
    output logic [N-1:0]           add_in1,
    output logic [N-1:0]           add_in2,
    output logic                   add_start,
    input  logic [N-1:0]           add_out,
    input  logic                   add_done,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [N-1:0]           res_data,
    output logic                   res_timeout,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [N-1:0]  NAR     = {1'b1, {(N-1){1'b0}}};
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2 || es < 0) begin : g_bad_params
        $error("posit_add_issue: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESULT
    } state_t;

    // Operand FIFO storage and bookkeeping
    logic [N-1:0]  r_mem_a [DEPTH];
    logic [N-1:0]  r_mem_b [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Issue FSM and registered outputs
    state_t        r_state;
    logic [N-1:0]  r_add_in1;
    logic [N-1:0]  r_add_in2;
    logic          r_add_start;
    logic [TW-1:0] r_wd;
    logic          r_res_valid;
    logic [N-1:0]  r_res_data;
    logic          r_res_timeout;
    logic          r_busy;

    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    logic          w_res_accept;
    logic [N-1:0]  w_head_a;
    logic [N-1:0]  w_head_b;

    assign in_ready     = (r_count < FULL);
    assign w_push       = in_valid && in_ready;
    assign w_nonempty   = (r_count != '0);
    assign w_res_accept = r_res_valid && res_ready;
    // The FIFO pops exactly when the FSM loads a new head into the operand registers.
    assign w_pop        = w_nonempty &&
                          ((r_state == S_IDLE) || (r_state == S_RESULT && w_res_accept));
    assign w_head_a     = r_mem_a[r_rd_ptr];
    assign w_head_b     = r_mem_b[r_rd_ptr];

    // NOTE: the storage array is deliberately not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_add_in1     <= '0;
            r_add_in2     <= '0;
            r_add_start   <= 1'b0;
            r_wd          <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_timeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            // NOTE: default-low here makes add_start a one-cycle pulse without a separate clear path.
            r_add_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_add_in1   <= w_head_a;
                        r_add_in2   <= w_head_b;
                        r_add_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the final watchdog cycle still wins.
                    if (add_done) begin
                        r_res_data    <= add_out;
                        r_res_timeout <= 1'b0;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_RESULT;
                    end else if (r_wd == WD_LAST) begin
                        r_res_data    <= NAR;
                        r_res_timeout <= 1'b1;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_RESULT;
                    end else begin
                        r_wd <= r_wd + TW'(1);
                    end
                end
                S_RESULT: begin
                    if (w_res_accept) begin
                        r_res_valid <= 1'b0;
                        if (w_pop) begin
                            r_add_in1   <= w_head_a;
                            r_add_in2   <= w_head_b;
                            r_add_start <= 1'b1;
                            r_state     <= S_LAUNCH;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign add_in1     = r_add_in1;
    assign add_in2     = r_add_in2;
    assign add_start   = r_add_start;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_timeout = r_res_timeout;
    assign busy        = r_busy;
    assign fifo_count  = r_count;

endmodule

// File: tb/tb_posit_add_issue.sv
// Scoreboard bench for posit_add_issue with a behavioural adder of programmable done latency.
// Expected sums are hand-computed posit32/es=2 values carried with each pushed pair.
module tb_posit_add_issue;

    localparam int N       = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam logic [31:0] NAR = 32'h8000_0000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } op_t;

    typedef struct {
        logic [31:0] data;
        logic        to;
    } res_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_a = '0;
    logic [N-1:0]  in_b = '0;
    logic [N-1:0]  add_in1;
    logic [N-1:0]  add_in2;
    logic          add_start;
    logic [N-1:0]  add_out = '0;
    logic          add_done = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [N-1:0]  res_data;
    logic          res_timeout;
    logic          busy;
    logic [CW-1:0] fifo_count;

    posit_add_issue #(.N(N), .es(2), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .add_in1     (add_in1),
        .add_in2     (add_in2),
        .add_start   (add_start),
        .add_out     (add_out),
        .add_done    (add_done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_timeout (res_timeout),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    op_t  op_q[$];
    res_t exp_q[$];

    int          lat = 2;
    bit          pending = 0;
    int          cnt = 0;
    op_t         cur;
    bit          stray = 0;
    logic [31:0] stray_val = '0;
    int          start_cyc = 0;
    bit          chk_turn = 0;
    int          last_acc_cyc = -10;
    int          push_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual=event required=none (t=%0t)", name, $time);
    endtask

    // Behavioural adder: done LAT cycles after start (LAT<=0 means never), plus stray pulses.
    always @(negedge clk) begin
        add_done = 1'b0;
        if (!reset) begin
            pending = 0;
            cnt = 0;
        end else begin
            if (add_start) begin
                if (op_q.size() == 0) begin
                    fail("unexpected_start");
                end else begin
                    cur = op_q.pop_front();
                    check("start_in1", 64'(add_in1), 64'(cur.a));
                    check("start_in2", 64'(add_in2), 64'(cur.b));
                    if (chk_turn) check("turnaround", 64'(cyc), 64'(last_acc_cyc + 1));
                    start_cyc = cyc;
                    pending = 1;
                    cnt = (lat > 0) ? lat : 0;
                end
            end else if (pending) begin
                check("start_pulse", 64'(add_start), 64'(0));
                check("in1_stable", 64'(add_in1), 64'(cur.a));
                check("in2_stable", 64'(add_in2), 64'(cur.b));
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        add_done = 1'b1;
                        add_out  = cur.sum;
                        pending  = 0;
                    end
                end
            end
            if (stray) begin
                add_done = 1'b1;
                add_out  = stray_val;
                stray    = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every result handshake.
    always @(negedge clk) begin
        res_t e;
        if (reset && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                fail("unexpected_result");
            end else begin
                e = exp_q.pop_front();
                check("res_data", 64'(res_data), 64'(e.data));
                check("res_timeout", 64'(res_timeout), 64'(e.to));
            end
            last_acc_cyc = cyc;
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sum,
                        input logic [31:0] rdata, input logic rto);
        int  budget = 300;
        bit  ok = 0;
        op_t o;
        res_t r;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!ok && budget > 0) begin
            @(negedge clk);
            if (in_ready) begin
                o.a = a; o.b = b; o.sum = sum;
                r.data = rdata; r.to = rto;
                op_q.push_back(o);
                exp_q.push_back(r);
                @(posedge clk);
                #1;
                push_cyc = cyc;
                ok = 1;
            end else begin
                budget--;
            end
        end
        in_valid = 1'b0;
        if (!ok) fail("push_timeout");
    endtask

    task automatic push_ok(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sum);
        push(a, b, sum, sum, 1'b0);
    endtask

    task automatic drain();
        int budget = 400;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            fail("drain_timeout");
            exp_q.delete();
            op_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, output int at);
        int budget = 300;
        at = -1;
        while (budget > 0) begin
            @(negedge clk);
            if (res_valid) begin
                at = cyc;
                break;
            end
            budget--;
        end
        if (at < 0) fail(name);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_add_in1"},   64'(add_in1), 64'(0));
        check({tag, "_add_in2"},   64'(add_in2), 64'(0));
        check({tag, "_add_start"}, 64'(add_start), 64'(0));
        check({tag, "_res_valid"}, 64'(res_valid), 64'(0));
        check({tag, "_res_data"},  64'(res_data), 64'(0));
        check({tag, "_res_to"},    64'(res_timeout), 64'(0));
        check({tag, "_busy"},      64'(busy), 64'(0));
        check({tag, "_count"},     64'(fifo_count), 64'(0));
        check({tag, "_in_ready"},  64'(in_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        int at;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset");

        // Single add 1.0 + 1.0 = 2.0, with issue latency
        @(posedge clk); #1;
        lat = 3;
        push_ok(32'h4000_0000, 32'h4000_0000, 32'h4800_0000);
        check("count_after_push", 64'(fifo_count), 64'(1));
        drain();
        check("issue_latency", 64'(start_cyc), 64'(push_cyc + 1));

        // Several sums with done on the first WAIT cycle
        lat = 1;
        push_ok(32'h4800_0000, 32'h4800_0000, 32'h5000_0000);
        push_ok(32'h5000_0000, 32'h5000_0000, 32'h5800_0000);
        push_ok(32'h4000_0000, 32'hC000_0000, 32'h0000_0000);
        push_ok(32'h4000_0000, 32'h4800_0000, 32'h4C00_0000);
        push_ok(32'h5800_0000, 32'h5800_0000, 32'h6000_0000);
        drain();

        // Back-pressure: first pair sits in RESULT, four more fill the FIFO, sixth refused
        lat = 2;
        res_ready = 1'b0;
        push_ok(32'h4000_0000, 32'h0000_0000, 32'h4000_0000);
        push_ok(32'h4800_0000, 32'h4800_0000, 32'h5000_0000);
        push_ok(32'h5000_0000, 32'h5000_0000, 32'h5800_0000);
        push_ok(32'h4000_0000, 32'hC000_0000, 32'h0000_0000);
        push_ok(32'h5800_0000, 32'h5800_0000, 32'h6000_0000);
        in_a = 32'h4000_0000;
        in_b = 32'h4800_0000;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", 64'(in_ready), 64'(0));
            check("full_count", 64'(fifo_count), 64'(DEPTH));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_res_valid", 64'(res_valid), 64'(1));
        check("bp_busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        chk_turn = 1;
        res_ready = 1'b1;
        drain();
        chk_turn = 0;

        // Watchdog: adder never answers
        lat = 0;
        push(32'h4000_0000, 32'h4800_0000, 32'h4C00_0000, NAR, 1'b1);
        wait_valid("wd_no_result", at);
        check("wd_latency", 64'(at - start_cyc), 64'(TIMEOUT + 1));
        drain();
        lat = 2;
        push_ok(32'h4000_0000, 32'h4800_0000, 32'h4C00_0000);
        drain();

        // Race: done on the last watchdog cycle wins
        lat = TIMEOUT;
        push_ok(32'h5000_0000, 32'h5000_0000, 32'h5800_0000);
        wait_valid("race_no_result", at);
        check("race_latency", 64'(at - start_cyc), 64'(TIMEOUT + 1));
        drain();

        // One cycle later the watchdog fires first and the late done is ignored
        lat = TIMEOUT + 1;
        push(32'h5800_0000, 32'h5800_0000, 32'h6000_0000, NAR, 1'b1);
        drain();

        // Stray done in IDLE
        repeat (2) @(posedge clk);
        #1;
        stray_val = 32'h1234_5678;
        stray = 1;
        repeat (3) @(negedge clk);
        check("stray_idle_busy", 64'(busy), 64'(0));
        check("stray_idle_valid", 64'(res_valid), 64'(0));
        check("stray_idle_data", 64'(res_data), 64'(NAR));
        check("stray_idle_to", 64'(res_timeout), 64'(1));

        // Stray done in RESULT while the consumer stalls
        @(posedge clk); #1;
        lat = 2;
        res_ready = 1'b0;
        push_ok(32'h5800_0000, 32'h5800_0000, 32'h6000_0000);
        wait_valid("stray_res_no_result", at);
        @(posedge clk); #1;
        stray_val = 32'hDEAD_BEEF;
        stray = 1;
        repeat (3) @(negedge clk);
        check("stray_res_data", 64'(res_data), 64'(32'h6000_0000));
        check("stray_res_valid", 64'(res_valid), 64'(1));
        check("stray_res_busy", 64'(busy), 64'(1));
        check("stray_res_to", 64'(res_timeout), 64'(0));
        @(posedge clk); #1;
        res_ready = 1'b1;
        drain();

        // Reset mid-WAIT with three pairs buffered
        lat = 0;
        push_ok(32'h4000_0000, 32'h4000_0000, 32'h4800_0000);
        push_ok(32'h4800_0000, 32'h4800_0000, 32'h5000_0000);
        push_ok(32'h5000_0000, 32'h5000_0000, 32'h5800_0000);
        push_ok(32'h5800_0000, 32'h5800_0000, 32'h6000_0000);
        @(negedge clk);
        check("pre_rst_count", 64'(fifo_count), 64'(3));
        check("pre_rst_busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        op_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        lat = 2;
        repeat (80) @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'(0));
        @(posedge clk); #1;
        push_ok(32'h4800_0000, 32'h4800_0000, 32'h5000_0000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
